// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: load/run/check harness around a single-cycle RV32 core.
// Define SEQ_FIRST_FAIL_EN to add the first-mismatch capture outputs.
module cpu_test_sequencer #(
  parameter int XLEN       = 32,
  parameter int IMEM_AW    = 6,
  parameter int NUM_CHECKS = 4,
  parameter int MAX_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [1:0]         ld_kind,
  input  logic [IMEM_AW-1:0] ld_addr,
  input  logic [XLEN-1:0]    ld_data,
  input  logic               ld_last,
  input  logic               restart,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic [4:0]         rf_raddr,
  input  logic [XLEN-1:0]    rf_rdata,
  output logic               cpu_rst_n,
  input  logic [XLEN-1:0]    cpu_pc,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [7:0]         fail_count,
  output logic [15:0]        cycle_count
`ifdef SEQ_FIRST_FAIL_EN
  ,
  output logic [4:0]         first_fail_idx,
  output logic [XLEN-1:0]    first_fail_data
`endif
);

  localparam int CW = $clog2(NUM_CHECKS + 1);
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam logic [CW-1:0] NUM_CHECKS_C = CW'(NUM_CHECKS);
  localparam logic [15:0]   CYC_LIMIT    = 16'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] halt_pc_q, halt_pc_d;
  logic [4:0]      chk_reg_q [NUM_CHECKS];
  logic [4:0]      chk_reg_d [NUM_CHECKS];
  logic [XLEN-1:0] chk_val_q [NUM_CHECKS];
  logic [XLEN-1:0] chk_val_d [NUM_CHECKS];
  logic [CW-1:0]   chk_cnt_q, chk_cnt_d;
  logic [CW-1:0]   chk_ptr_q, chk_ptr_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     cycle_count_q, cycle_count_d;
  logic [7:0]      fail_count_q, fail_count_d;
  logic            timeout_q, timeout_d;
  logic            pass_q, pass_d;
  logic            done_q, done_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic            ld_ready_q, ld_ready_d;
`ifdef SEQ_FIRST_FAIL_EN
  logic [4:0]      ff_idx_q, ff_idx_d;
  logic [XLEN-1:0] ff_data_q, ff_data_d;
`endif

  logic [IW-1:0]   wr_idx_s;
  logic [IW-1:0]   rd_idx_s;
  logic [15:0]     cyc_inc_s;

  assign wr_idx_s  = chk_cnt_q[IW-1:0];
  assign rd_idx_s  = chk_ptr_q[IW-1:0];
  assign cyc_inc_s = (cycle_count_q == 16'hFFFF) ? cycle_count_q : cycle_count_q + 16'd1;

  // Next-state, table updates and the combinational load/readback strobes.
  always_comb begin
    state_d       = state_q;
    halt_pc_d     = halt_pc_q;
    chk_reg_d     = chk_reg_q;
    chk_val_d     = chk_val_q;
    chk_cnt_d     = chk_cnt_q;
    chk_ptr_d     = chk_ptr_q;
    ovf_d         = ovf_q;
    cycle_count_d = cycle_count_q;
    fail_count_d  = fail_count_q;
    timeout_d     = timeout_q;
`ifdef SEQ_FIRST_FAIL_EN
    ff_idx_d      = ff_idx_q;
    ff_data_d     = ff_data_q;
`endif
    imem_we       = 1'b0;
    imem_waddr    = {IMEM_AW{1'b0}};
    imem_wdata    = {XLEN{1'b0}};
    rf_we         = 1'b0;
    rf_waddr      = 5'd0;
    rf_wdata      = {XLEN{1'b0}};
    rf_raddr      = 5'd0;

    case (state_q)
      S_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          case (ld_kind)
            2'b00: begin
              imem_we    = 1'b1;
              imem_waddr = ld_addr;
              imem_wdata = ld_data;
            end
            2'b01: begin
              rf_we    = (ld_addr[4:0] != 5'd0);
              rf_waddr = ld_addr[4:0];
              rf_wdata = ld_data;
            end
            2'b10: begin
              // A full table drops the entry but remembers it so pass cannot be claimed.
              if (chk_cnt_q == NUM_CHECKS_C) begin
                ovf_d = 1'b1;
              end else begin
                chk_reg_d[wr_idx_s] = ld_addr[4:0];
                chk_val_d[wr_idx_s] = ld_data;
                chk_cnt_d           = chk_cnt_q + CW'(1);
              end
            end
            2'b11: halt_pc_d = ld_data;
            default: halt_pc_d = halt_pc_q;
          endcase
          if (ld_last) begin
            state_d = S_RUN;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end

      S_RUN: begin
        // Halt has priority: the halting cycle is not counted as executed.
        if (cpu_pc == halt_pc_q) begin
          state_d = S_CHECK;
        end else begin
          cycle_count_d = cyc_inc_s;
          if (cyc_inc_s >= CYC_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = S_CHECK;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_CHECK: begin
        if (chk_cnt_q == CW'(0)) begin
          state_d = S_DONE;
        end else begin
          rf_raddr = chk_reg_q[rd_idx_s];
          if (rf_rdata != chk_val_q[rd_idx_s]) begin
            fail_count_d = (fail_count_q == 8'hFF) ? fail_count_q : fail_count_q + 8'd1;
`ifdef SEQ_FIRST_FAIL_EN
            if (fail_count_q == 8'd0) begin
              ff_idx_d  = chk_reg_q[rd_idx_s];
              ff_data_d = rf_rdata;
            end else begin
              ff_idx_d  = ff_idx_q;
              ff_data_d = ff_data_q;
            end
`endif
          end else begin
            fail_count_d = fail_count_q;
          end
          chk_ptr_d = chk_ptr_q + CW'(1);
          if (chk_ptr_q == chk_cnt_q - CW'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CHECK;
          end
        end
      end

      S_DONE: begin
        if (restart) begin
          state_d       = S_LOAD;
          halt_pc_d     = {XLEN{1'b1}};
          chk_cnt_d     = CW'(0);
          chk_ptr_d     = CW'(0);
          ovf_d         = 1'b0;
          cycle_count_d = 16'd0;
          fail_count_d  = 8'd0;
          timeout_d     = 1'b0;
`ifdef SEQ_FIRST_FAIL_EN
          ff_idx_d      = 5'd0;
          ff_data_d     = {XLEN{1'b0}};
`endif
        end else begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_LOAD;
    endcase

    ld_ready_d  = (state_d == S_LOAD);
    cpu_rst_n_d = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    pass_d      = (state_d == S_DONE) && (fail_count_d == 8'd0) && !timeout_d && !ovf_d;
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_LOAD;
      halt_pc_q     <= {XLEN{1'b1}};
      chk_reg_q     <= '{default: 5'd0};
      chk_val_q     <= '{default: {XLEN{1'b0}}};
      chk_cnt_q     <= CW'(0);
      chk_ptr_q     <= CW'(0);
      ovf_q         <= 1'b0;
      cycle_count_q <= 16'd0;
      fail_count_q  <= 8'd0;
      timeout_q     <= 1'b0;
      pass_q        <= 1'b0;
      done_q        <= 1'b0;
      cpu_rst_n_q   <= 1'b0;
      ld_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      halt_pc_q     <= halt_pc_d;
      chk_reg_q     <= chk_reg_d;
      chk_val_q     <= chk_val_d;
      chk_cnt_q     <= chk_cnt_d;
      chk_ptr_q     <= chk_ptr_d;
      ovf_q         <= ovf_d;
      cycle_count_q <= cycle_count_d;
      fail_count_q  <= fail_count_d;
      timeout_q     <= timeout_d;
      pass_q        <= pass_d;
      done_q        <= done_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      ld_ready_q    <= ld_ready_d;
    end
  end

`ifdef SEQ_FIRST_FAIL_EN
  // First-mismatch capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_idx_q  <= 5'd0;
      ff_data_q <= {XLEN{1'b0}};
    end else begin
      ff_idx_q  <= ff_idx_d;
      ff_data_q <= ff_data_d;
    end
  end

  assign first_fail_idx  = ff_idx_q;
  assign first_fail_data = ff_data_q;
`endif

  assign ld_ready    = ld_ready_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_count  = fail_count_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Bench for cpu_test_sequencer: a tiny add/sub core stand-in plus an ISA-level
// reference model that predicts each run's results from the loaded stream.
module tb_cpu_test_sequencer;
  localparam int XLEN = 32;
  localparam int AW   = 6;
  localparam int NC   = 4;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, ld_valid, ld_ready, ld_last, restart;
  logic [1:0]      ld_kind;
  logic [AW-1:0]   ld_addr;
  logic [XLEN-1:0] ld_data;
  logic            imem_we, rf_we, cpu_rst_n, done, pass, timeout;
  logic [AW-1:0]   imem_waddr;
  logic [XLEN-1:0] imem_wdata, rf_wdata, rf_rdata, cpu_pc;
  logic [4:0]      rf_waddr, rf_raddr;
  logic [7:0]      fail_count;
  logic [15:0]     cycle_count;
`ifdef SEQ_FIRST_FAIL_EN
  logic [4:0]      first_fail_idx;
  logic [XLEN-1:0] first_fail_data;
`endif

  cpu_test_sequencer #(.XLEN(XLEN), .IMEM_AW(AW), .NUM_CHECKS(NC), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_kind(ld_kind),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .restart(restart),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .cpu_rst_n(cpu_rst_n), .cpu_pc(cpu_pc), .done(done), .pass(pass),
    .timeout(timeout), .fail_count(fail_count), .cycle_count(cycle_count)
`ifdef SEQ_FIRST_FAIL_EN
    , .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int phase   = 0;   // 0 idle, 1 streaming load beats, 2 running/checking

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_alu(input logic [31:0] ins);
    return (ins[6:0] == 7'h33) && (ins[14:12] == 3'd0) &&
           ((ins[31:25] == 7'h00) || (ins[31:25] == 7'h20));
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    return (ins[30]) ? a - b : a + b;
  endfunction

  // Core stand-in: IMEM, register file, PC; executes add/sub, everything else is a nop.
  logic [31:0] env_imem [64];
  logic [31:0] env_rf   [32];
  logic [31:0] core_pc;
  logic [31:0] core_ins, core_a, core_b;
  assign core_ins = env_imem[core_pc[7:2]];
  assign core_a   = (core_ins[19:15] == 5'd0) ? 32'd0 : env_rf[core_ins[19:15]];
  assign core_b   = (core_ins[24:20] == 5'd0) ? 32'd0 : env_rf[core_ins[24:20]];
  assign cpu_pc   = core_pc;
  assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : env_rf[rf_raddr];

  initial begin
    for (int i = 0; i < 64; i++) env_imem[i] = 32'd0;
    for (int i = 0; i < 32; i++) env_rf[i] = 32'd0;
    core_pc = 32'd0;
  end

  always @(posedge clk) begin
    if (imem_we) env_imem[imem_waddr] <= imem_wdata;
    if (rf_we) env_rf[rf_waddr] <= rf_wdata;
    if (!cpu_rst_n) core_pc <= 32'd0;
    else begin
      if (is_alu(core_ins) && core_ins[11:7] != 5'd0)
        env_rf[core_ins[11:7]] <= alu(core_ins, core_a, core_b);
      core_pc <= core_pc + 32'd4;
    end
  end

  // Reference model state, fed only from the stimulus the bench itself issues.
  logic [31:0] m_imem [64];
  logic [31:0] m_rf   [32];
  logic [31:0] m_halt;
  logic [36:0] m_chk [$];
  int          e_cycles, e_fail;
  logic        e_timeout, e_pass;
  logic [4:0]  e_ff_idx;
  logic [31:0] e_ff_data;

  initial begin
    for (int i = 0; i < 64; i++) m_imem[i] = 32'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_halt = 32'hFFFF_FFFF;
  end

  function automatic void m_exec(input logic [31:0] ins);
    if (is_alu(ins) && ins[11:7] != 5'd0)
      m_rf[ins[11:7]] = alu(ins, m_rf[ins[19:15]], m_rf[ins[24:20]]);
  endfunction

  // Step the program instruction by instruction; the instruction at the halt PC
  // still retires because the core is only put back in reset one cycle later.
  task automatic model_run();
    logic [31:0] pc = 32'd0;
    logic [31:0] act;
    int          n = 0;
    bit          stop = 1'b0;
    bit          ovf;
    e_timeout = 1'b0;
    while (!stop) begin
      m_exec(m_imem[pc[7:2]]);
      if (pc == m_halt) stop = 1'b1;
      else begin
        n++;
        pc = pc + 32'd4;
        if (n >= MAXC - 1) begin e_timeout = 1'b1; stop = 1'b1; end
      end
    end
    e_cycles  = n;
    e_fail    = 0;
    e_ff_idx  = 5'd0;
    e_ff_data = 32'd0;
    ovf = (m_chk.size() > NC);
    for (int i = 0; i < m_chk.size() && i < NC; i++) begin
      act = m_rf[m_chk[i][36:32]];
      if (act != m_chk[i][31:0]) begin
        if (e_fail == 0) begin e_ff_idx = m_chk[i][36:32]; e_ff_data = act; end
        e_fail++;
      end
    end
    e_pass = (e_fail == 0) && !e_timeout && !ovf;
  endtask

  // Per-cycle checks of the load strobes and of the handshake outside loading.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_we) chk("rf_we_x0", {31'd0, rf_waddr != 5'd0}, 32'd1);
      if (phase == 1) begin
        chk("ld_ready_load", ld_ready, 1'b1);
        chk("cpu_rst_n_load", cpu_rst_n, 1'b0);
        chk("imem_we", imem_we, ld_valid && ld_kind == 2'b00);
        if (ld_valid && ld_kind == 2'b00) begin
          chk("imem_waddr", imem_waddr, ld_addr);
          chk("imem_wdata", imem_wdata, ld_data);
        end
        chk("rf_we", rf_we, ld_valid && ld_kind == 2'b01 && ld_addr[4:0] != 5'd0);
        if (ld_valid && ld_kind == 2'b01 && ld_addr[4:0] != 5'd0) begin
          chk("rf_waddr", rf_waddr, ld_addr[4:0]);
          chk("rf_wdata", rf_wdata, ld_data);
        end
      end else if (phase == 2) begin
        chk("ld_ready_busy", ld_ready, 1'b0);
        chk("imem_we_busy", imem_we, 1'b0);
      end
    end
  end

  task automatic beat(input logic [1:0] k, input logic [5:0] a, input logic [31:0] d,
                      input bit last, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        ld_valid = 1'b0;
        ld_kind  = 2'($urandom);
        ld_addr  = 6'($urandom);
        ld_data  = $urandom;
        ld_last  = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    ld_valid = 1'b1; ld_kind = k; ld_addr = a; ld_data = d; ld_last = last;
    @(posedge clk);
    case (k)
      2'b00: m_imem[a] = d;
      2'b01: if (a[4:0] != 5'd0) m_rf[a[4:0]] = d;
      2'b10: m_chk.push_back({a[4:0], d});
      default: m_halt = d;
    endcase
    if (last) phase = 2;
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic model_clear();
    m_chk.delete();
    m_halt = 32'hFFFF_FFFF;
  endtask

  task automatic do_restart();
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    model_clear();
    phase = 1;
  endtask

  task automatic wait_done(input string tag);
    model_run();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_pass"}, pass, e_pass);
    chk({tag, "_timeout"}, timeout, e_timeout);
    chk({tag, "_fail_count"}, fail_count, e_fail);
    chk({tag, "_cycle_count"}, cycle_count, e_cycles);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
`ifdef SEQ_FIRST_FAIL_EN
    chk({tag, "_ff_idx"}, first_fail_idx, e_ff_idx);
    chk({tag, "_ff_data"}, first_fail_data, e_ff_data);
`endif
    @(negedge clk);
    chk({tag, "_done_hold"}, done, 1'b1);
    chk({tag, "_pass_hold"}, pass, e_pass);
    phase = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_kind = 2'b00; ld_addr = '0; ld_data = '0;
    ld_last = 1'b0; restart = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_fail_count", fail_count, 8'd0);
    chk("rst_cycle_count", cycle_count, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    phase = 1;

    // 1: add x1,x2,x3 halting at PC 4
    beat(2'b00, 6'd0, 32'h003100B3, 1'b0, 1'b0);
    beat(2'b01, 6'd2, 32'd10, 1'b0, 1'b0);
    beat(2'b01, 6'd3, 32'd20, 1'b0, 1'b0);
    beat(2'b10, 6'd1, 32'd30, 1'b0, 1'b0);
    beat(2'b11, 6'd0, 32'd4, 1'b1, 1'b0);
    wait_done("t1");
    chk("t1_lit_pass", pass, 1'b1);
    chk("t1_lit_cycles", cycle_count, 16'd1);

    // 2: sub x4,x5,x6 at word 1, two checks
    do_restart();
    beat(2'b00, 6'd1, 32'h40628233, 1'b0, 1'b0);
    beat(2'b01, 6'd5, 32'd50, 1'b0, 1'b0);
    beat(2'b01, 6'd6, 32'd15, 1'b0, 1'b0);
    beat(2'b10, 6'd4, 32'd35, 1'b0, 1'b0);
    beat(2'b10, 6'd1, 32'd30, 1'b0, 1'b0);
    beat(2'b11, 6'd0, 32'd8, 1'b1, 1'b0);
    wait_done("t2");
    chk("t2_lit_pass", pass, 1'b1);
    chk("t2_lit_fail", fail_count, 8'd0);

    // 3: wrong expectation for x4
    do_restart();
    beat(2'b10, 6'd4, 32'd36, 1'b0, 1'b0);
    beat(2'b10, 6'd1, 32'd30, 1'b0, 1'b0);
    beat(2'b11, 6'd0, 32'd8, 1'b1, 1'b0);
    wait_done("t3");
    chk("t3_lit_pass", pass, 1'b0);
    chk("t3_lit_fail", fail_count, 8'd1);
    chk("t3_model_ff_idx", e_ff_idx, 5'd4);
    chk("t3_model_ff_data", e_ff_data, 32'd35);

    // 4: no halt PC -> timeout even though the check matches
    do_restart();
    beat(2'b10, 6'd1, 32'd30, 1'b1, 1'b0);
    wait_done("t4");
    chk("t4_lit_timeout", timeout, 1'b1);
    chk("t4_lit_cycles", cycle_count, 16'(MAXC - 1));
    chk("t4_lit_pass", pass, 1'b0);

    // 4b: halt lands on the same cycle the budget would expire; halt wins
    do_restart();
    beat(2'b10, 6'd1, 32'd30, 1'b0, 1'b0);
    beat(2'b11, 6'd0, 32'h3F8, 1'b1, 1'b0);
    wait_done("t4b");
    chk("t4b_lit_timeout", timeout, 1'b0);
    chk("t4b_lit_cycles", cycle_count, 16'(MAXC - 2));
    chk("t4b_lit_pass", pass, 1'b1);

    // 5: five check entries overflow a four-entry table
    do_restart();
    beat(2'b10, 6'd1, 32'd30, 1'b0, 1'b0);
    beat(2'b10, 6'd2, 32'd10, 1'b0, 1'b0);
    beat(2'b10, 6'd3, 32'd20, 1'b0, 1'b0);
    beat(2'b10, 6'd5, 32'd50, 1'b0, 1'b0);
    beat(2'b10, 6'd6, 32'd15, 1'b0, 1'b0);
    beat(2'b11, 6'd0, 32'd4, 1'b1, 1'b0);
    wait_done("t5");
    chk("t5_lit_pass", pass, 1'b0);
    chk("t5_lit_fail", fail_count, 8'd0);

    // 6: x0 preload, gapped valid, reset mid-run, then clean reload
    do_restart();
    beat(2'b01, 6'd0, 32'h0000DEAD, 1'b0, 1'b1);
    beat(2'b00, 6'd2, 32'd0, 1'b0, 1'b1);
    beat(2'b11, 6'd0, 32'h40, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_cpu_rst_n_run", cpu_rst_n, 1'b1);
    phase = 0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_ld_ready", ld_ready, 1'b1);
    chk("t6_rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("t6_rst_cycles", cycle_count, 16'd0);
    chk("t6_rst_done", done, 1'b0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    phase = 1;
    beat(2'b01, 6'd2, 32'd3, 1'b0, 1'b1);
    beat(2'b01, 6'd3, 32'd4, 1'b0, 1'b1);
    beat(2'b10, 6'd1, 32'd7, 1'b0, 1'b1);
    beat(2'b10, 6'd0, 32'd0, 1'b0, 1'b1);
    beat(2'b11, 6'd0, 32'd4, 1'b1, 1'b1);
    wait_done("t6");
    chk("t6_lit_pass", pass, 1'b1);
    chk("t6_lit_cycles", cycle_count, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
